// File: rtl/riscv_pkg.sv
// Shared encodings for the multicycle RISC-V control path: opcodes, ALU codes,
// datapath mux selects, immediate formats and the control FSM state type.
package riscv_pkg;

  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_BR  = 7'b1100011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [6:0] OP_LUI = 7'b0110111;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SHL   = 3'b001;
  localparam logic [2:0] ALU_AND   = 3'b010;
  localparam logic [2:0] ALU_LAND  = 3'b011;
  localparam logic [2:0] ALU_GE    = 3'b100;
  localparam logic [2:0] ALU_PASSB = 3'b101;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_MEM    = 2'b01;
  localparam logic [1:0] RES_ALU    = 2'b10;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC_R   = 4'd6,
    S_EXEC_I   = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_LUI      = 4'd11
  } state_e;

  function automatic logic [2:0] imm_src_of(input logic [6:0] op);
    case (op)
      OP_SW:   return IMM_S;
      OP_BR:   return IMM_B;
      OP_JAL:  return IMM_J;
      OP_LUI:  return IMM_U;
      default: return IMM_I;
    endcase
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// funct3 to ALU operation map for R/I-type arithmetic, plus a legality flag
// so DECODE can reject unsupported funct3 values before execution.
module alu_decoder
  import riscv_pkg::*;
(
  input  logic [2:0] funct3,
  output logic [2:0] alu_control,
  output logic       funct3_legal
);

  always_comb begin
    alu_control  = ALU_ADD;
    funct3_legal = 1'b1;
    case (funct3)
      3'b000:  alu_control = ALU_ADD;
      3'b001:  alu_control = ALU_SHL;
      3'b111:  alu_control = ALU_AND;
      3'b110:  alu_control = ALU_LAND;
      3'b101:  alu_control = ALU_GE;
      default: funct3_legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle RISC-V datapath: Moore outputs per state,
// with pc_write additionally following the ALU zero flag in BRANCH.
//   state    | meaning
//   FETCH    | read instruction at PC, PC <= PC+4
//   DECODE   | branch target into ALUOut, dispatch on op
//   MEMADR   | rs1 + imm address for lw/sw
//   MEMREAD  | load data from ALUOut address
//   MEMWB    | write load data to rd
//   MEMWRITE | store rs2 to ALUOut address
//   EXEC_R/I | ALU op on rs1 with rs2 / immediate
//   ALUWB    | write ALUOut to rd
//   BRANCH   | compare rs1 >= rs2, redirect PC when taken
//   JAL      | PC <= target, compute old PC + 4
//   LUI      | pass immediate through ALU
module multicycle_control
  import riscv_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       zero,
  output logic       pc_write,
  output logic       adr_src,
  output logic       mem_write,
  output logic       ir_write,
  output logic       reg_write,
  output logic [1:0] result_src,
  output logic [1:0] alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] imm_src,
  output logic [2:0] alu_control,
  output logic       illegal_instr
);

  state_e     state_q, state_d;
  logic [2:0] f3_alu;
  logic       f3_legal;
  logic       op_legal;
  logic       pc_write_c, mem_write_c, ir_write_c, reg_write_c, illegal_c;

  alu_decoder u_alu_decoder (
    .funct3      (funct3),
    .alu_control (f3_alu),
    .funct3_legal(f3_legal)
  );

  always_comb begin
    op_legal = 1'b0;
    case (op)
      OP_LW, OP_SW, OP_BR, OP_JAL, OP_LUI: op_legal = 1'b1;
      OP_R, OP_I:                          op_legal = f3_legal;
      default:                             op_legal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= S_FETCH;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    case (state_q)
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        if (op_legal) begin
          case (op)
            OP_LW, OP_SW: state_d = S_MEMADR;
            OP_R:         state_d = S_EXEC_R;
            OP_I:         state_d = S_EXEC_I;
            OP_BR:        state_d = S_BRANCH;
            OP_JAL:       state_d = S_JAL;
            OP_LUI:       state_d = S_LUI;
            default:      state_d = S_FETCH;
          endcase
        end
      end
      S_MEMADR:  state_d = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD: state_d = S_MEMWB;
      S_EXEC_R:  state_d = S_ALUWB;
      S_EXEC_I:  state_d = S_ALUWB;
      S_JAL:     state_d = S_ALUWB;
      S_LUI:     state_d = S_ALUWB;
      default:   state_d = S_FETCH;
    endcase
  end

  always_comb begin
    pc_write_c  = 1'b0;
    mem_write_c = 1'b0;
    ir_write_c  = 1'b0;
    reg_write_c = 1'b0;
    illegal_c   = 1'b0;
    adr_src     = 1'b0;
    result_src  = RES_ALUOUT;
    alu_src_a   = SRCA_PC;
    alu_src_b   = SRCB_RS2;
    alu_control = ALU_ADD;
    imm_src     = imm_src_of(op);
    case (state_q)
      S_FETCH: begin
        ir_write_c = 1'b1;
        pc_write_c = 1'b1;
        alu_src_b  = SRCB_FOUR;
        result_src = RES_ALU;
      end
      S_DECODE: begin
        alu_src_a = SRCA_OLDPC;
        alu_src_b = SRCB_IMM;
        illegal_c = ~op_legal;
      end
      S_MEMADR: begin
        alu_src_a = SRCA_RS1;
        alu_src_b = SRCB_IMM;
      end
      S_MEMREAD: adr_src = 1'b1;
      S_MEMWB: begin
        result_src  = RES_MEM;
        reg_write_c = 1'b1;
      end
      S_MEMWRITE: begin
        adr_src     = 1'b1;
        mem_write_c = 1'b1;
      end
      S_EXEC_R: begin
        alu_src_a   = SRCA_RS1;
        alu_control = f3_alu;
      end
      S_EXEC_I: begin
        alu_src_a   = SRCA_RS1;
        alu_src_b   = SRCB_IMM;
        alu_control = f3_alu;
      end
      S_ALUWB: reg_write_c = 1'b1;
      S_BRANCH: begin
        alu_src_a   = SRCA_RS1;
        alu_control = ALU_GE;
        pc_write_c  = ~zero;
      end
      S_JAL: begin
        alu_src_a  = SRCA_OLDPC;
        alu_src_b  = SRCB_FOUR;
        pc_write_c = 1'b1;
      end
      S_LUI: begin
        alu_src_b   = SRCB_IMM;
        alu_control = ALU_PASSB;
      end
      default: ;
    endcase
  end

  // Reset kills every write enable in the same cycle it rises.
  assign pc_write      = pc_write_c  & ~reset;
  assign mem_write     = mem_write_c & ~reset;
  assign ir_write      = ir_write_c  & ~reset;
  assign reg_write     = reg_write_c & ~reset;
  assign illegal_instr = illegal_c   & ~reset;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: each instruction is expanded into
// its expected per-cycle output vectors and compared cycle by cycle.
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [6:0] op = 7'd0;
  logic [2:0] funct3 = 3'd0;
  logic       zero = 1'b0;
  logic       pc_write, adr_src, mem_write, ir_write, reg_write, illegal_instr;
  logic [1:0] result_src, alu_src_a, alu_src_b;
  logic [2:0] imm_src, alu_control;

  int checks = 0;
  int errors = 0;

  multicycle_control dut (
    .clk          (clk),
    .reset        (reset),
    .op           (op),
    .funct3       (funct3),
    .zero         (zero),
    .pc_write     (pc_write),
    .adr_src      (adr_src),
    .mem_write    (mem_write),
    .ir_write     (ir_write),
    .reg_write    (reg_write),
    .result_src   (result_src),
    .alu_src_a    (alu_src_a),
    .alu_src_b    (alu_src_b),
    .imm_src      (imm_src),
    .alu_control  (alu_control),
    .illegal_instr(illegal_instr)
  );

  always #5 clk = ~clk;

  // {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, src_a, src_b, imm_src, alu_control, illegal}
  function automatic logic [17:0] vec(input logic pc, adr, mw, ir, rw, input logic [1:0] rs, a, b,
                                      input logic [2:0] imm, alu, input logic ill);
    return {pc, adr, mw, ir, rw, rs, a, b, imm, alu, ill};
  endfunction

  function automatic logic [17:0] observed();
    return {pc_write, adr_src, mem_write, ir_write, reg_write, result_src, alu_src_a, alu_src_b,
            imm_src, alu_control, illegal_instr};
  endfunction

  function automatic logic [2:0] imm_of(input logic [6:0] o);
    case (o)
      7'b0100011: return 3'b001;
      7'b1100011: return 3'b010;
      7'b1101111: return 3'b011;
      7'b0110111: return 3'b100;
      default:    return 3'b000;
    endcase
  endfunction

  // Returns 1 and the ALU code when funct3 names a supported operation.
  function automatic logic f3_map(input logic [2:0] f, output logic [2:0] code);
    case (f)
      3'd0: begin code = 3'b000; return 1'b1; end
      3'd1: begin code = 3'b001; return 1'b1; end
      3'd7: begin code = 3'b010; return 1'b1; end
      3'd6: begin code = 3'b011; return 1'b1; end
      3'd5: begin code = 3'b100; return 1'b1; end
      default: begin code = 3'b000; return 1'b0; end
    endcase
  endfunction

  task automatic check(input logic [17:0] exp, input string tag);
    logic [17:0] obs;
    obs = observed();
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %05h expected %05h", tag, obs, exp);
    end
  endtask

  // Expected vector sequence for one instruction, from its class.
  task automatic build(input logic [6:0] o, input logic [2:0] f, input logic z,
                       output logic [17:0] q[$]);
    logic [2:0] imm, code;
    logic       ok;
    logic [17:0] aluwb;
    imm   = imm_of(o);
    ok    = f3_map(f, code);
    aluwb = vec(0, 0, 0, 0, 1, 2'b00, 2'b00, 2'b00, imm, 3'b000, 0);
    q = {};
    q.push_back(vec(1, 0, 0, 1, 0, 2'b10, 2'b00, 2'b10, imm, 3'b000, 0));
    if (o == 7'b0000011 || o == 7'b0100011 || o == 7'b1100011 || o == 7'b1101111 ||
        o == 7'b0110111 || ((o == 7'b0110011 || o == 7'b0010011) && ok))
      q.push_back(vec(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 0));
    else begin
      q.push_back(vec(0, 0, 0, 0, 0, 2'b00, 2'b01, 2'b01, imm, 3'b000, 1));
      return;
    end
    case (o)
      7'b0000011: begin
        q.push_back(vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm, 3'b000, 0));
        q.push_back(vec(0, 1, 0, 0, 0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 0));
        q.push_back(vec(0, 0, 0, 0, 1, 2'b01, 2'b00, 2'b00, imm, 3'b000, 0));
      end
      7'b0100011: begin
        q.push_back(vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm, 3'b000, 0));
        q.push_back(vec(0, 1, 1, 0, 0, 2'b00, 2'b00, 2'b00, imm, 3'b000, 0));
      end
      7'b0110011: begin
        q.push_back(vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, imm, code, 0));
        q.push_back(aluwb);
      end
      7'b0010011: begin
        q.push_back(vec(0, 0, 0, 0, 0, 2'b00, 2'b10, 2'b01, imm, code, 0));
        q.push_back(aluwb);
      end
      7'b1100011:
        q.push_back(vec(~z, 0, 0, 0, 0, 2'b00, 2'b10, 2'b00, imm, 3'b100, 0));
      7'b1101111: begin
        q.push_back(vec(1, 0, 0, 0, 0, 2'b00, 2'b01, 2'b10, imm, 3'b000, 0));
        q.push_back(aluwb);
      end
      default: begin
        q.push_back(vec(0, 0, 0, 0, 0, 2'b00, 2'b00, 2'b01, imm, 3'b101, 0));
        q.push_back(aluwb);
      end
    endcase
  endtask

  // Called just after a rising edge with the DUT in FETCH; returns likewise.
  task automatic run_instr(input logic [6:0] o, input logic [2:0] f, input logic z, input string name);
    logic [17:0] q[$];
    build(o, f, z, q);
    op = o; funct3 = f; zero = z;
    for (int k = 0; k < q.size(); k++) begin
      @(negedge clk);
      check(q[k], $sformatf("%s cyc%0d", name, k));
      @(posedge clk);
      #1;
    end
  endtask

  logic [17:0] q_sw[$];
  logic [17:0] rst_vec;
  logic [6:0]  ops[8];
  logic [6:0]  r_op;

  initial begin
    ops = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011,
            7'b1100011, 7'b1101111, 7'b0110111, 7'b1111111};
    rst_vec = vec(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b000, 3'b000, 0);

    repeat (2) begin
      @(negedge clk);
      check(rst_vec, "in_reset");
    end
    @(posedge clk); #1;
    reset = 1'b0;

    run_instr(7'b0000011, 3'd2, 1'b0, "lw");
    run_instr(7'b0100011, 3'd2, 1'b1, "sw");
    run_instr(7'b0110011, 3'd1, 1'b0, "r_shl");
    run_instr(7'b0110011, 3'd6, 1'b1, "r_land");
    run_instr(7'b0110011, 3'd2, 1'b0, "r_illegal_f3");
    run_instr(7'b0010011, 3'd5, 1'b0, "i_ge");
    run_instr(7'b1100011, 3'd5, 1'b0, "br_taken");
    run_instr(7'b1100011, 3'd5, 1'b1, "br_not_taken");
    run_instr(7'b1101111, 3'd0, 1'b1, "jal");
    run_instr(7'b0110111, 3'd3, 1'b0, "lui");
    run_instr(7'b1111111, 3'd0, 1'b0, "op_illegal");

    // Reset while a store is in MEMWRITE must drop mem_write immediately.
    build(7'b0100011, 3'd2, 1'b0, q_sw);
    op = 7'b0100011; funct3 = 3'd2; zero = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      check(q_sw[k], $sformatf("sw_pre_reset cyc%0d", k));
      if (k < 3) begin @(posedge clk); #1; end
    end
    #1 reset = 1'b1;
    #1 check(vec(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b001, 3'b000, 0), "reset_mid_memwrite");
    @(posedge clk); #1;
    @(negedge clk);
    check(vec(0, 0, 0, 0, 0, 2'b10, 2'b00, 2'b10, 3'b001, 3'b000, 0), "reset_held");
    @(posedge clk); #1;
    reset = 1'b0;
    run_instr(7'b0110011, 3'd7, 1'b0, "after_reset_r_and");

    for (int n = 0; n < 80; n++) begin
      r_op = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ops[$urandom_range(0, 7)];
      run_instr(r_op, 3'($urandom), 1'($urandom), $sformatf("rnd%0d op%07b", n, r_op));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_control.md
# multicycle_control

Main control FSM for the multicycle RISC-V datapath; sits directly upstream of the ALU and drives its 3-bit `control` input, operand-select muxes, and all architectural write enables. Decodes opcode/funct3 from the instruction register, sequences each instruction through fetch, decode, execute, memory and writeback states, and resolves branches from the ALU `zero` flag. Moore-style outputs; only `pc_write` depends combinationally on `zero`.

## Interface
- No parameters.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-high; returns FSM to FETCH
- `op`  in  7  instruction[6:0]
- `funct3`  in  3  instruction[14:12]
- `zero`  in  1  ALU zero flag, same cycle
- `pc_write`  out  1  PC register enable
- `adr_src`  out  1  memory address: 0=PC, 1=ALUOut
- `mem_write`  out  1  data memory write enable
- `ir_write`  out  1  instruction/old-PC register enable
- `reg_write`  out  1  register file write enable
- `result_src`  out  2  00=ALUOut, 01=mem data, 10=ALU result
- `alu_src_a`  out  2  00=PC, 01=old PC, 10=rs1 data
- `alu_src_b`  out  2  00=rs2 data, 01=immediate, 10=constant 4
- `imm_src`  out  3  000=I, 001=S, 010=B, 011=J, 100=U
- `alu_control`  out  3  ALU op: 000 add, 001 shl, 010 and, 011 logical-and, 100 ge, 101 pass-B
- `illegal_instr`  out  1  one-cycle pulse in DECODE on unsupported op/funct3

## Operation
- Default for every output not listed in a state: 0. `imm_src` decoded from `op` in all states (lw/I-type→000, sw→001, branch→010, jal→011, lui→100, else 000).
- FETCH: adr_src=0, ir_write=1, src_a=00, src_b=10, add, result_src=10, pc_write=1 → DECODE.
- DECODE: src_a=01, src_b=01, add (branch target into ALUOut). Next by `op`: 0000011/0100011→MEMADR; 0110011→EXEC_R; 0010011→EXEC_I; 1100011→BRANCH; 1101111→JAL; 0110111→LUI; other→FETCH with illegal_instr=1.
- MEMADR: src_a=10, src_b=01, add → MEMREAD if lw, MEMWRITE if sw.
- MEMREAD: adr_src=1 → MEMWB. MEMWB: result_src=01, reg_write=1 → FETCH.
- MEMWRITE: adr_src=1, mem_write=1 → FETCH.
- EXEC_R: src_a=10, src_b=00, alu_control=decode(funct3) → ALUWB. EXEC_I: same with src_b=01.
- funct3 decode: 000→000, 001→001, 111→010, 110→011, 101→100; others illegal (flagged in DECODE, FETCH next).
- ALUWB: result_src=00, reg_write=1 → FETCH.
- BRANCH (bge-style): src_a=10, src_b=00, alu_control=100, result_src=00; pc_write = ~zero (taken when rs1≥rs2) → FETCH.
- JAL: src_a=01, src_b=10, add, result_src=00, pc_write=1 (PC←target in ALUOut; ALU computes old PC+4) → ALUWB.
- LUI: src_b=01, alu_control=101 → ALUWB.

## Timing
- State register updates on rising `clk`; outputs combinational from state (+`zero`, `op`, `funct3`).
- While `reset`=1: state=FETCH and pc_write, mem_write, ir_write, reg_write, illegal_instr forced 0; muxes/alu_control show FETCH values. First fetch on the first edge after deassertion.
- Reset mid-instruction aborts it; no write enable asserts after reset rises, even within the same cycle.
- Cycles per instruction: lw 5, sw 4, R 4, I 4, branch 3, jal 4, lui 4, illegal 2.
- Write enables are one cycle wide; never two of reg_write/mem_write/ir_write together.
- Unreachable state encodings → FETCH next cycle, all enables 0.

## Structure
- `riscv_pkg`: opcode constants, ALU control codes, mux select codes, imm_src codes, 4-bit state enum.
- Sub-module `alu_decoder`: combinational funct3→alu_control plus `funct3_legal`; instantiated once.
- FSM: one state register, one next-state block, one output block.

## Test plan
- Reset asserted mid-MEMWRITE → mem_write drops same cycle; after release state=FETCH, ir_write=1, pc_write=1.
- lw (op 0000011) → FETCH, DECODE, MEMADR, MEMREAD, MEMWB; reg_write=1 with result_src=01 only in cycle 5.
- R-type funct3=001 → EXEC_R alu_control=001, src_b=00; funct3=110 → 011; funct3=010 → illegal_instr pulse, back to FETCH after 2 cycles.
- Branch with zero=0 → pc_write=1 in BRANCH; zero=1 → pc_write=0; both return to FETCH, 3 cycles.
- jal → JAL pc_write=1, src_a=01, src_b=10; then ALUWB reg_write=1; lui → alu_control=101, imm_src=100, then ALUWB.
- op=1111111 → illegal_instr=1 for exactly one cycle, no write enable asserted, FETCH next.
